// File: rtl/bootloader_pkg.sv
// Opcodes, FSM state type and built-in program images for the RAM bootloader.
// Words are {opcode[3:0], operand[3:0]}.
package bootloader_pkg;

    localparam logic [3:0] NOOP    = 4'h0;
    localparam logic [3:0] LOAD_A  = 4'h1;
    localparam logic [3:0] ADD     = 4'h2;
    localparam logic [3:0] SUB     = 4'h3;
    localparam logic [3:0] STORE_A = 4'h4;
    localparam logic [3:0] LOAD_IM = 4'h5;
    localparam logic [3:0] JUMP    = 4'h6;
    localparam logic [3:0] JUMPC   = 4'h7;
    localparam logic [3:0] JUMPZ   = 4'h8;
    localparam logic [3:0] OUT     = 4'h9;
    localparam logic [3:0] HALT    = 4'hF;

    typedef enum logic [1:0] {ST_ADDR, ST_DATA, ST_DONE} state_e;

    // 0 = count-in-ones (mem[15] holds the increment), 1 = Fibonacci, others all NOOP.
    function automatic logic [7:0] prog_word(input int prog, input int addr);
        logic [7:0] w;
        w = {NOOP, 4'h0};
        if (prog == 0) begin
            case (addr)
                0:       w = {LOAD_IM, 4'h0};
                1:       w = {OUT,     4'h0};
                2:       w = {ADD,     4'hF};
                3:       w = {JUMPC,   4'h0};
                4:       w = {JUMP,    4'h1};
                15:      w = 8'h01;
                default: w = {NOOP, 4'h0};
            endcase
        end else if (prog == 1) begin
            // mem[13]=x, mem[14]=y, mem[15]=scratch; halts on carry out
            case (addr)
                0:       w = {LOAD_A,  4'hD};
                1:       w = {ADD,     4'hE};
                2:       w = {JUMPC,   4'hA};
                3:       w = {STORE_A, 4'hF};
                4:       w = {LOAD_A,  4'hE};
                5:       w = {STORE_A, 4'hD};
                6:       w = {LOAD_A,  4'hF};
                7:       w = {STORE_A, 4'hE};
                8:       w = {OUT,     4'h0};
                9:       w = {JUMP,    4'h0};
                10:      w = {HALT,    4'h0};
                14:      w = 8'h01;
                default: w = {NOOP, 4'h0};
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/bootloader_multi_if.sv
// Bootloader control/status and CPU-bus write-path signals.
// master = bootloader side, slave = bus/controller side.
interface bootloader_multi_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_W      = 2
);
    logic [SEL_W-1:0]      program_select;
    logic                  enable_bootload;
    logic                  start;
    logic                  bus_ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  bootload_address;
    logic                  bootload_ram;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] checksum;

    modport master (
        input  program_select, enable_bootload, start, bus_ready,
        output data, bootload_address, bootload_ram, busy, done, checksum
    );

    modport slave (
        output program_select, enable_bootload, start, bus_ready,
        input  data, bootload_address, bootload_ram, busy, done, checksum
    );
endinterface

// File: rtl/bootloader_rom.sv
// Combinational program ROM: (sel, addr) -> word; out-of-range selects read as NOOP.
// Zero latency, no flow control.
module bootloader_rom
    import bootloader_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int NUM_PROGRAMS = 4,
    parameter int SEL_W        = 2
) (
    input  logic [SEL_W-1:0]      sel_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] word_o
);
    always_comb begin
        word_o = '0;
        if (int'(sel_i) < NUM_PROGRAMS)
            word_o = DATA_WIDTH'(prog_word(int'(sel_i), int'(addr_i)));
    end
endmodule

// File: rtl/bootloader_multi.sv
// Streams address/data beat pairs from a selectable program ROM into CPU RAM, with checksum.
// Latency: one beat per cycle, full load in 2*2**ADDR_WIDTH cycles when unstalled.
// Backpressure: bus_ready=0 or enable_bootload=0 holds the current beat and all state.
module bootloader_multi
    import bootloader_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int NUM_PROGRAMS = 4
) (
    input logic                clk,
    input logic                rst_n,
    bootloader_multi_if.master bus
);
    localparam int SEL_W = (NUM_PROGRAMS > 1) ? $clog2(NUM_PROGRAMS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [DATA_WIDTH-1:0] rom_word;
    logic [DATA_WIDTH-1:0] bus_data;
    logic                  addr_stb, ram_stb, done_w;

    bootloader_rom #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_PROGRAMS(NUM_PROGRAMS),
        .SEL_W       (SEL_W)
    ) u_rom (
        .sel_i (sel_q),
        .addr_i(addr_q),
        .word_o(rom_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ADDR;
            addr_q  <= '0;
            sel_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        sum_d    = sum_q;
        addr_stb = 1'b0;
        ram_stb  = 1'b0;
        bus_data = '0;
        case (state_q)
            ST_ADDR: begin
                addr_stb = rst_n && bus.enable_bootload;
                if (addr_stb) bus_data = DATA_WIDTH'(addr_q);
                // Only the very first beat of a load can sit at ADDR/0, so select stays open until it is taken.
                if (addr_q == '0) sel_d = bus.program_select;
                if (addr_stb && bus.bus_ready) state_d = ST_DATA;
            end
            ST_DATA: begin
                ram_stb = rst_n && bus.enable_bootload;
                if (ram_stb) bus_data = rom_word;
                if (ram_stb && bus.bus_ready) begin
                    sum_d = sum_q + rom_word;
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_ADDR;
                    addr_d  = '0;
                    sum_d   = '0;
                end
            end
            default: state_d = ST_ADDR;
        endcase
    end

    assign done_w               = rst_n && (state_q == ST_DONE);
    assign bus.data             = bus_data;
    assign bus.bootload_address = addr_stb;
    assign bus.bootload_ram     = ram_stb;
    assign bus.busy             = rst_n && (state_q != ST_DONE);
    assign bus.done             = done_w;
    assign bus.checksum         = done_w ? sum_q : '0;
endmodule

// File: tb/tb_bootloader_multi.sv
// Directed bench for bootloader_multi: loads, stalls, pauses, restarts and mid-load reset.
module tb_bootloader_multi;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bootloader_multi_if #(.DATA_WIDTH(8), .SEL_W(2)) bus ();

    bootloader_multi #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (4),
        .NUM_PROGRAMS(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] img0 [16] = '{8'h50, 8'h90, 8'h2F, 8'h70, 8'h61, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    logic [7:0] img1 [16] = '{8'h1D, 8'h2E, 8'h7A, 8'h4F, 8'h1E, 8'h4D, 8'h1F, 8'h4E,
                              8'h90, 8'h60, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};

    logic [7:0] words   [16];
    logic [7:0] tr_data [128];
    logic       tr_adr  [128];
    logic       tr_ram  [128];
    int         beats, done_cyc, rdy_from, rdy_len, en_from, en_len, start_at, chg_at;
    logic [1:0] chg_val;
    logic       overlap, en_viol, busy_gap;
    logic [3:0] cur_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clear_plan();
        rdy_from = -1; rdy_len = 0;
        en_from  = -1; en_len  = 0;
        start_at = -1; chg_at  = -1; chg_val = 2'd0;
    endtask

    // Drives one cycle per iteration from a negedge, samples 1 ns later; stops at done or budget.
    task automatic run_load(input int budget);
        beats = 0; done_cyc = -1; overlap = 0; en_viol = 0; busy_gap = 0; cur_addr = 4'd0;
        for (int a = 0; a < 16; a++) words[a] = 8'hEE;
        for (int i = 0; i < budget && i < 128; i++) begin
            bus.bus_ready       = !(i >= rdy_from && i < rdy_from + rdy_len);
            bus.enable_bootload = !(i >= en_from && i < en_from + en_len);
            bus.start           = (i == start_at);
            if (i == chg_at) bus.program_select = chg_val;
            #1;
            if (bus.done) begin
                done_cyc = i;
                break;
            end
            tr_data[i] = bus.data;
            tr_adr[i]  = bus.bootload_address;
            tr_ram[i]  = bus.bootload_ram;
            if (bus.bootload_address && bus.bootload_ram) overlap = 1;
            if (!bus.busy) busy_gap = 1;
            if (!bus.enable_bootload && (bus.bootload_address || bus.bootload_ram || bus.data != 8'h00))
                en_viol = 1;
            if (bus.bootload_ram && bus.bus_ready) begin
                words[cur_addr] = bus.data;
                beats++;
            end
            if (bus.bootload_address && bus.bus_ready) cur_addr = bus.data[3:0];
            @(negedge clk);
        end
        bus.start = 1'b0; bus.bus_ready = 1'b1; bus.enable_bootload = 1'b1;
    endtask

    task automatic check_load(input string tag, input int prog, input int exp_done, input logic [7:0] exp_sum);
        chk({tag, "_done_cyc"}, done_cyc, exp_done);
        chk({tag, "_beats"}, beats, 16);
        chk({tag, "_overlap"}, overlap, 0);
        chk({tag, "_busy_gap"}, busy_gap, 0);
        chk({tag, "_busy_end"}, bus.busy, 0);
        chk({tag, "_checksum"}, bus.checksum, exp_sum);
        for (int a = 0; a < 16; a++) begin
            logic [7:0] e;
            e = (prog == 0) ? img0[a] : (prog == 1) ? img1[a] : 8'h00;
            chk($sformatf("%s_w%0d", tag, a), words[a], e);
        end
    endtask

    task automatic restart(input logic [1:0] sel);
        bus.program_select = sel;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data"}, bus.data, 0);
        chk({tag, "_adr"}, bus.bootload_address, 0);
        chk({tag, "_ram"}, bus.bootload_ram, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_sum"}, bus.checksum, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.enable_bootload = 1'b1;
        bus.bus_ready       = 1'b1;
        bus.program_select  = 2'd0;
        bus.start           = 1'b0;
        clear_plan();
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("rst");

        // Auto-load after reset, program 0
        @(negedge clk);
        rst_n = 1'b1;
        run_load(100);
        chk("p0_c0_adr", tr_adr[0], 1);
        chk("p0_c0_data", tr_data[0], 8'h00);
        chk("p0_c1_ram", tr_ram[1], 1);
        chk("p0_c1_data", tr_data[1], 8'h50);
        chk("p0_c31_data", tr_data[31], 8'h01);
        chk("p0_done", bus.done, 1);
        check_load("p0", 0, 32, 8'hE1);

        // Bus stall on the data beat of address 5, Fibonacci image
        restart(2'd1);
        clear_plan();
        rdy_from = 11; rdy_len = 3;
        run_load(100);
        for (int c = 11; c <= 14; c++) begin
            chk($sformatf("stall_ram_c%0d", c), tr_ram[c], 1);
            chk($sformatf("stall_data_c%0d", c), tr_data[c], 8'h4D);
        end
        check_load("stall", 1, 35, 8'hCD);

        // Pause via enable for 4 cycles starting on the address beat of address 4
        restart(2'd0);
        clear_plan();
        en_from = 8; en_len = 4;
        run_load(100);
        chk("pause_viol", en_viol, 0);
        chk("pause_resume_adr", tr_adr[12], 1);
        chk("pause_resume_data", tr_data[12], 8'h04);
        check_load("pause", 0, 36, 8'hE1);

        // Fibonacci reload; select changes after the first beat must not matter
        restart(2'd1);
        clear_plan();
        chg_at = 3; chg_val = 2'd0;
        run_load(100);
        chk("fib_w2", words[2], 8'h7A);
        chk("fib_w14", words[14], 8'h01);
        check_load("fib", 1, 32, 8'hCD);

        // Start pulse while busy is ignored
        restart(2'd0);
        clear_plan();
        start_at = 14;
        run_load(100);
        check_load("busy_start", 0, 32, 8'hE1);

        // Unpopulated program slot loads all NOOP
        restart(2'd3);
        clear_plan();
        run_load(100);
        check_load("noop", 3, 32, 8'h00);

        // Reset asserted during the address beat of address 9
        restart(2'd0);
        clear_plan();
        run_load(18);
        #1;
        chk("pre_rst_adr", bus.bootload_address, 1);
        chk("pre_rst_data", bus.data, 8'h09);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_load(100);
        chk("post_rst_c0_adr", tr_adr[0], 1);
        chk("post_rst_c0_data", tr_data[0], 8'h00);
        check_load("post_rst", 0, 32, 8'hE1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
